vga_scanline_fetch: RTL and testbench
=====================================

Name: vga_scanline_fetch

Overview:
- Memory-sharing scheduler between the VGA timing generator and a single-port frame memory.
- Each visible line, it pre-fetches that line's pixel words into a ping-pong line buffer during horizontal blanking.
- Outside fetch windows, it grants a host read/write port access to the same memory.
- Sits between the timing counter (hpos/vpos), the frame RAM, and the pixel scan-out logic.

Parameters:
- ADDR_W, 17, frame memory word-address width.
- DATA_W, 32, memory/line-buffer word width.
- LB_AW, 7, line-buffer address width per bank.
- WORDS_PER_LINE, 100, words fetched per visible line; must be ≤ 2**LB_AW.
- BASE_ADDR, 0, word address of row 0.
- FETCH_START_H, 0, hpos at which the fetch triggers.
- H_VISIBLE_START, 256, hpos deadline; fetch must be complete before this.
- V_VISIBLE_START, 28, first visible vpos.
- V_VISIBLE_END, 628, one past last visible vpos.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_hpos  in  11  horizontal counter from timing generator.
- i_vpos  in  10  vertical counter from timing generator.
- i_host_req  in  1  host access request; held until granted.
- i_host_we  in  1  1=write, 0=read.
- i_host_addr  in  ADDR_W  host word address.
- i_host_wdata  in  DATA_W  host write data.
- o_host_gnt  out  1  combinational grant; access happens this cycle.
- o_host_rvalid  out  1  read data valid, one cycle after a granted read.
- o_host_rdata  out  DATA_W  host read data.
- o_mem_en  out  1  memory enable.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_rdata  in  DATA_W  memory read data, 1-cycle latency.
- o_lb_we  out  1  line-buffer write strobe.
- o_lb_wbank  out  1  bank being written (always ~o_lb_rbank).
- o_lb_addr  out  LB_AW  line-buffer write address.
- o_lb_wdata  out  DATA_W  line-buffer write data.
- o_lb_rbank  out  1  bank the scan-out reads.
- o_fetch_busy  out  1  high in FETCH or DRAIN.
- o_underrun  out  1  sticky missed-deadline flag.

Behaviour:
- Reset values:
  - State IDLE.
  - o_lb_rbank=0, o_underrun=0, o_host_rvalid=0, o_lb_we=0, word counter=0, line base=BASE_ADDR.
  - Reset mid-fetch aborts immediately; no further lb writes.
- Trigger:
  - Condition: i_hpos==FETCH_START_H and V_VISIBLE_START ≤ i_vpos < V_VISIBLE_END.
  - On trigger, line base is set to BASE_ADDR if i_vpos==V_VISIBLE_START, else to previous base + WORDS_PER_LINE.
  - The base update happens even if the previous fetch aborted.
- States:
  - IDLE → FETCH on trigger.
  - FETCH: each cycle, mem_en=1, we=0, addr=base+count, count++.
    - After issuing count==WORDS_PER_LINE-1 → DRAIN.
  - DRAIN: one cycle for the final read return → IDLE; o_lb_rbank toggles at the end of DRAIN.
  - Any state except IDLE → IDLE with o_underrun set if i_hpos==H_VISIBLE_START while not yet toggled.
    - On underrun, o_lb_rbank does not toggle.
- Line-buffer write:
  - Registered one cycle after each fetch read.
  - o_lb_we=1, o_lb_addr=word index, o_lb_wdata=i_mem_rdata.
  - Goes to bank ~o_lb_rbank.
- Host arbitration:
  - o_host_gnt = i_host_req & state==IDLE & ~trigger. Fetch always wins.
  - On grant, mem port is driven from the host inputs.
  - For a granted read, o_host_rvalid=1 next cycle and o_host_rdata=i_mem_rdata.
  - With no grant and no fetch, mem_en=0.
  - Worst-case host wait is WORDS_PER_LINE+2 cycles.
- Counter wrap:
  - Trigger is re-evaluated on the line following vpos wrap.
  - Non-visible lines never fetch.
- Arithmetic: base addition wraps modulo 2**ADDR_W.

Test Plan:
1. Reset, then run to vpos=28 hpos=0 → mem reads addr 0..99 at hpos 1..100; o_lb_we hpos 2..101 with lb_addr 0..99 into bank 1; o_lb_rbank 0→1 visible at hpos 102.
2. Continue to vpos=29 → reads addr 100..199 into bank 0, rbank→0; at vpos=628 no fetch occurs; after frame wrap, vpos=28 again restarts at addr 0.
3. Host read req held from hpos 0 of vpos=28 → gnt first asserted at hpos 102 (IDLE), rvalid at hpos 103 with memory content; host write at vpos=5 → granted same cycle, mem_we=1.
4. Host req asserted exactly at trigger cycle → gnt=0 that cycle; fetch proceeds uninterrupted.
5. WORDS_PER_LINE=300 → at hpos 256 the fetch aborts, o_underrun=1 (stays 1), rbank unchanged, next line base=BASE_ADDR+300.
6. Assert i_rst at hpos 50 mid-fetch → next cycle o_lb_we=0, state IDLE, rbank=0, base=BASE_ADDR; normal fetch at next visible line.

Source files
------------

// File: rtl/vga_scanline_fetch.sv
// Scanline pre-fetch scheduler: copies each visible line from the frame memory
// into a ping-pong line buffer during hblank, and lends the memory port to the host otherwise.
module vga_scanline_fetch #(
    parameter int ADDR_W          = 17,
    parameter int DATA_W          = 32,
    parameter int LB_AW           = 7,
    parameter int WORDS_PER_LINE  = 100,
    parameter int BASE_ADDR       = 0,
    parameter int FETCH_START_H   = 0,
    parameter int H_VISIBLE_START = 256,
    parameter int V_VISIBLE_START = 28,
    parameter int V_VISIBLE_END   = 628
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [10:0]       i_hpos,
    input  logic [9:0]        i_vpos,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_lb_we,
    output logic              o_lb_wbank,
    output logic [LB_AW-1:0]  o_lb_addr,
    output logic [DATA_W-1:0] o_lb_wdata,
    output logic              o_lb_rbank,
    output logic              o_fetch_busy,
    output logic              o_underrun
);

    // state | meaning
    // IDLE  | no fetch in flight; host may own the memory port
    // FETCH | issuing one line read per cycle
    // DRAIN | waiting for the last read to land, then swap banks

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(WORDS_PER_LINE);
    localparam logic [LB_AW-1:0]  LAST_IDX   = LB_AW'(WORDS_PER_LINE - 1);
    localparam logic [10:0]       H_TRIG     = 11'(FETCH_START_H);
    localparam logic [10:0]       H_DEADLINE = 11'(H_VISIBLE_START);
    localparam logic [9:0]        V_FIRST    = 10'(V_VISIBLE_START);
    localparam logic [9:0]        V_END      = 10'(V_VISIBLE_END);

    state_t            state, state_nxt;
    logic [LB_AW-1:0]  cnt;
    logic [ADDR_W-1:0] line_base;
    logic              trigger, deadline;
    logic              fetch_issue, bank_toggle, abort;

    assign trigger  = (i_hpos == H_TRIG) && (i_vpos >= V_FIRST) && (i_vpos < V_END);
    assign deadline = (i_hpos == H_DEADLINE);

    // A deadline hit cancels the cycle's read and the bank swap alike.
    always_comb begin
        state_nxt   = state;
        fetch_issue = 1'b0;
        bank_toggle = 1'b0;
        abort       = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (deadline) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    fetch_issue = 1'b1;
                    if (cnt == LAST_IDX) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_IDLE;
                if (deadline) abort = 1'b1;
                else          bank_toggle = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_host_gnt = i_host_req && (state == S_IDLE) && !trigger;

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (fetch_issue) begin
            o_mem_en   = 1'b1;
            o_mem_addr = line_base + ADDR_W'(cnt);
        end else if (o_host_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_host_we;
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            line_base     <= BASE;
            o_lb_rbank    <= 1'b0;
            o_underrun    <= 1'b0;
            o_host_rvalid <= 1'b0;
            o_lb_we       <= 1'b0;
            o_lb_addr     <= '0;
        end else begin
            state <= state_nxt;
            // Base advances on every visible trigger, aborted line or not.
            if (trigger)
                line_base <= (i_vpos == V_FIRST) ? BASE : line_base + LINE_STEP;
            if (state == S_IDLE)
                cnt <= '0;
            else if (fetch_issue)
                cnt <= cnt + 1'b1;
            o_lb_we       <= fetch_issue;
            o_lb_addr     <= cnt;
            o_host_rvalid <= o_host_gnt && !i_host_we;
            if (abort)       o_underrun <= 1'b1;
            if (bank_toggle) o_lb_rbank <= !o_lb_rbank;
        end
    end

    assign o_lb_wbank   = !o_lb_rbank;
    assign o_lb_wdata   = i_mem_rdata;
    assign o_host_rdata = i_mem_rdata;
    assign o_fetch_busy = (state != S_IDLE);

endmodule

// File: tb/tb_vga_scanline_fetch.sv
// Bench for vga_scanline_fetch: directed line table, hand-written host/reset
// sequences and randomized host traffic against a line-timeline reference model.
module tb_vga_scanline_fetch;

    localparam int WPL  = 100;
    localparam int HV   = 256;
    localparam int MSZ  = 131072;
    localparam int LLEN = 300;

    logic        clk;
    logic        i_rst;
    logic [10:0] i_hpos;
    logic [9:0]  i_vpos;
    logic        i_host_req, i_host_we;
    logic [16:0] i_host_addr;
    logic [31:0] i_host_wdata;
    logic        o_host_gnt, o_host_rvalid;
    logic [31:0] o_host_rdata;
    logic        o_mem_en, o_mem_we;
    logic [16:0] o_mem_addr;
    logic [31:0] o_mem_wdata, i_mem_rdata;
    logic        o_lb_we, o_lb_wbank, o_lb_rbank, o_fetch_busy, o_underrun;
    logic [6:0]  o_lb_addr;
    logic [31:0] o_lb_wdata;

    // second instance: line too long for the hblank window
    logic        h2_req, h2_we;
    logic [16:0] h2_addr;
    logic [31:0] h2_wdata, mem_rdata_2;
    logic        gnt_2, rvalid_2, en_2, we_2, lbwe_2, wbank_2, rbank_2, busy_2, und_2;
    logic [31:0] rdata_2, wdata_2, lbwdata_2;
    logic [16:0] addr_2;
    logic [8:0]  lbaddr_2;

    vga_scanline_fetch dut (
        .i_clk(clk), .i_rst(i_rst), .i_hpos(i_hpos), .i_vpos(i_vpos),
        .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
        .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
        .o_host_rdata(o_host_rdata), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_lb_we(o_lb_we), .o_lb_wbank(o_lb_wbank), .o_lb_addr(o_lb_addr),
        .o_lb_wdata(o_lb_wdata), .o_lb_rbank(o_lb_rbank), .o_fetch_busy(o_fetch_busy),
        .o_underrun(o_underrun)
    );

    vga_scanline_fetch #(.LB_AW(9), .WORDS_PER_LINE(300)) dut2 (
        .i_clk(clk), .i_rst(i_rst), .i_hpos(i_hpos), .i_vpos(i_vpos),
        .i_host_req(h2_req), .i_host_we(h2_we), .i_host_addr(h2_addr),
        .i_host_wdata(h2_wdata), .o_host_gnt(gnt_2), .o_host_rvalid(rvalid_2),
        .o_host_rdata(rdata_2), .o_mem_en(en_2), .o_mem_we(we_2),
        .o_mem_addr(addr_2), .o_mem_wdata(wdata_2), .i_mem_rdata(mem_rdata_2),
        .o_lb_we(lbwe_2), .o_lb_wbank(wbank_2), .o_lb_addr(lbaddr_2),
        .o_lb_wdata(lbwdata_2), .o_lb_rbank(rbank_2), .o_fetch_busy(busy_2),
        .o_underrun(und_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // frame memory with one-cycle read latency
    logic [31:0] mem [0:MSZ-1];
    initial for (int i = 0; i < MSZ; i++) mem[i] = init_word(i);
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
            i_mem_rdata <= mem[o_mem_addr];
        end
    end

    int n_vec, n_err, cur_ln, cur_h;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (line %0d hpos %0d)", name, act, exp, cur_ln, cur_h);
        end
    endtask

    typedef struct {
        int ln; int h;
        bit en; int addr; bit lbwe; int lbaddr; logic [31:0] lbdata; bit rbank; bit busy;
        bit c2; bit en2; int addr2; bit busy2; bit und2; bit rbank2;
    } vec_t;
    vec_t tbl[$];

    // reference model: expectations derived from where we are on the line
    logic [31:0] shadow [0:MSZ-1];
    bit  model_on, m_line, m_rbank, m_under, m_prev_rd;
    int  m_base;
    logic [31:0] m_prev_data;
    bit  exp_gnt;

    bit  hreq_pend, hwe, rand_mode, script_armed;
    int  haddr, hs_h0, hs_addr;
    bit  hs_we;
    logic [31:0] hwdata, hs_wdata;

    task automatic model_step(input int v, input int h);
        bit vis, trig, frd, busy, lbwe;
        int faddr;
        vis = (v >= 28) && (v < 628);
        trig = (h == 0) && vis;
        if (h == 0) begin
            m_line = vis;
            if (vis) m_base = (v == 28) ? 0 : (m_base + WPL) % MSZ;
        end
        frd  = m_line && h >= 1 && h <= WPL && h < HV;
        busy = m_line && h >= 1 && h <= WPL + 1 && h < HV;
        lbwe = m_line && h >= 2 && (h - 1) <= WPL && (h - 1) < HV;
        exp_gnt = hreq_pend && !busy && !trig;
        faddr = (m_base + h - 1) % MSZ;
        if (model_on) begin
            chk("host_gnt", 64'(o_host_gnt), 64'(exp_gnt));
            chk("mem_en", 64'(o_mem_en), 64'(frd || exp_gnt));
            if (frd) begin
                chk("fetch_we", 64'(o_mem_we), 64'd0);
                chk("fetch_addr", 64'(o_mem_addr), 64'(faddr));
            end else if (exp_gnt) begin
                chk("host_mem_we", 64'(o_mem_we), 64'(hwe));
                chk("host_mem_addr", 64'(o_mem_addr), 64'(haddr));
                if (hwe) chk("host_mem_wdata", 64'(o_mem_wdata), 64'(hwdata));
            end
            chk("lb_we", 64'(o_lb_we), 64'(lbwe));
            if (lbwe) begin
                chk("lb_addr", 64'(o_lb_addr), 64'(h - 2));
                chk("lb_wdata", 64'(o_lb_wdata), 64'(shadow[(m_base + h - 2) % MSZ]));
            end
            chk("lb_rbank", 64'(o_lb_rbank), 64'(m_rbank));
            chk("lb_wbank", 64'(o_lb_wbank), 64'(!m_rbank));
            chk("fetch_busy", 64'(o_fetch_busy), 64'(busy));
            chk("underrun", 64'(o_underrun), 64'(m_under));
            chk("host_rvalid", 64'(o_host_rvalid), 64'(m_prev_rd));
            if (m_prev_rd) chk("host_rdata", 64'(o_host_rdata), 64'(m_prev_data));
        end
        m_prev_rd = exp_gnt && !hwe;
        if (m_prev_rd) m_prev_data = shadow[haddr];
        if (exp_gnt && hwe) shadow[haddr] = hwdata;
        if (m_line && h == WPL + 1 && WPL + 1 < HV) m_rbank = !m_rbank;
        if (m_line && h == HV && WPL + 1 >= HV) m_under = 1'b1;
        if (i_rst) begin
            m_rbank = 1'b0; m_base = 0; m_line = 1'b0; m_prev_rd = 1'b0; m_under = 1'b0;
        end
    endtask

    task automatic table_checks();
        foreach (tbl[i]) begin
            if (tbl[i].ln == cur_ln && tbl[i].h == cur_h) begin
                chk("t_mem_en", 64'(o_mem_en), 64'(tbl[i].en));
                if (tbl[i].en) chk("t_mem_addr", 64'(o_mem_addr), 64'(tbl[i].addr));
                chk("t_lb_we", 64'(o_lb_we), 64'(tbl[i].lbwe));
                if (tbl[i].lbwe) begin
                    chk("t_lb_addr", 64'(o_lb_addr), 64'(tbl[i].lbaddr));
                    chk("t_lb_wdata", 64'(o_lb_wdata), 64'(tbl[i].lbdata));
                end
                chk("t_rbank", 64'(o_lb_rbank), 64'(tbl[i].rbank));
                chk("t_busy", 64'(o_fetch_busy), 64'(tbl[i].busy));
                if (tbl[i].c2) begin
                    chk("t2_mem_en", 64'(en_2), 64'(tbl[i].en2));
                    if (tbl[i].en2) chk("t2_mem_addr", 64'(addr_2), 64'(tbl[i].addr2));
                    chk("t2_busy", 64'(busy_2), 64'(tbl[i].busy2));
                    chk("t2_underrun", 64'(und_2), 64'(tbl[i].und2));
                    chk("t2_rbank", 64'(rbank_2), 64'(tbl[i].rbank2));
                end
            end
        end
    endtask

    task automatic hand_checks();
        if (cur_ln == 6 && cur_h == 51) begin
            chk("rst_lb_we", 64'(o_lb_we), 64'd0);
            chk("rst_busy", 64'(o_fetch_busy), 64'd0);
            chk("rst_rbank", 64'(o_lb_rbank), 64'd0);
        end
        if (cur_ln == 7 && cur_h == 1) chk("rst_next_base", 64'(o_mem_addr), 64'd100);
        if (cur_ln == 7 && cur_h == 102) chk("rst_next_rbank", 64'(o_lb_rbank), 64'd1);
        if (cur_ln == 8 && cur_h == 0) chk("trig_gnt", 64'(o_host_gnt), 64'd0);
        if (cur_ln == 8 && cur_h == 1) chk("trig_fetch_addr", 64'(o_mem_addr), 64'd0);
        if (cur_ln == 8 && cur_h == 101) chk("drain_gnt", 64'(o_host_gnt), 64'd0);
        if (cur_ln == 8 && cur_h == 102) begin
            chk("idle_gnt", 64'(o_host_gnt), 64'd1);
            chk("idle_gnt_addr", 64'(o_mem_addr), 64'd5);
        end
        if (cur_ln == 8 && cur_h == 103) begin
            chk("rd_rvalid", 64'(o_host_rvalid), 64'd1);
            chk("rd_rdata", 64'(o_host_rdata), 64'(init_word(5)));
        end
        if (cur_ln == 9 && cur_h == 10) begin
            chk("wr_gnt", 64'(o_host_gnt), 64'd1);
            chk("wr_mem_we", 64'(o_mem_we), 64'd1);
            chk("wr_mem_addr", 64'(o_mem_addr), 64'd7);
        end
        if (cur_ln == 10 && cur_h == 21) begin
            chk("rb_rvalid", 64'(o_host_rvalid), 64'd1);
            chk("rb_rdata", 64'(o_host_rdata), 64'h0000_0000_CAFE_0001);
        end
    endtask

    task automatic do_cycle(input int ln, input int v, input int h, input bit rst);
        @(negedge clk);
        cur_ln = ln; cur_h = h;
        i_rst  = rst;
        i_hpos = 11'(h);
        i_vpos = 10'(v);
        if (!hreq_pend && !rst) begin
            if (rand_mode && $urandom_range(0, 3) == 0) begin
                hreq_pend = 1'b1;
                hwe    = 1'($urandom_range(0, 1));
                haddr  = $urandom_range(0, 1023);
                hwdata = $urandom;
            end else if (script_armed && h == hs_h0) begin
                hreq_pend = 1'b1; script_armed = 1'b0;
                hwe = hs_we; haddr = hs_addr; hwdata = hs_wdata;
            end
        end
        i_host_req   = hreq_pend;
        i_host_we    = hwe;
        i_host_addr  = 17'(haddr);
        i_host_wdata = hwdata;
        #1;
        model_step(v, h);
        if (model_on) begin
            table_checks();
            hand_checks();
        end
        if (exp_gnt) hreq_pend = 1'b0;
    endtask

    task automatic run_line(input int ln, input int v, input int rst_at);
        for (int h = 0; h < LLEN; h++) do_cycle(ln, v, h, h == rst_at);
    endtask

    task automatic arm(input int h0, input bit we, input int a, input logic [31:0] d);
        script_armed = 1'b1; hs_h0 = h0; hs_we = we; hs_addr = a; hs_wdata = d;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        for (int i = 0; i < MSZ; i++) shadow[i] = init_word(i);
        model_on = 0; m_line = 0; m_rbank = 0; m_under = 0; m_prev_rd = 0; m_base = 0;
        m_prev_data = '0; exp_gnt = 0;
        hreq_pend = 0; hwe = 0; haddr = 0; hwdata = '0; rand_mode = 0; script_armed = 0;
        hs_h0 = 0; hs_we = 0; hs_addr = 0; hs_wdata = '0;
        h2_req = 0; h2_we = 0; h2_addr = '0; h2_wdata = '0; mem_rdata_2 = '0;
        i_rst = 1; i_hpos = '0; i_vpos = '0;
        i_host_req = 0; i_host_we = 0; i_host_addr = '0; i_host_wdata = '0;

        //             ln  h  en addr lbwe lba  lbdata          rb busy c2 en2 a2  b2 u2 rb2
        tbl.push_back('{0,   0, 0,  0,  0,  0, 32'h0,           0, 0,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{1,   0, 0,  0,  0,  0, 32'h0,           0, 0,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{1,   1, 1,  0,  0,  0, 32'h0,           0, 1,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{1,   2, 1,  1,  1,  0, init_word(0),    0, 1,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{1, 100, 1, 99,  1, 98, init_word(98),   0, 1,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{1, 101, 0,  0,  1, 99, init_word(99),   0, 1,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{1, 102, 0,  0,  0,  0, 32'h0,           1, 0,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{1, 255, 0,  0,  0,  0, 32'h0,           1, 0,  1, 1, 254, 1, 0, 0});
        tbl.push_back('{1, 256, 0,  0,  0,  0, 32'h0,           1, 0,  1, 0,  0,  1, 0, 0});
        tbl.push_back('{1, 257, 0,  0,  0,  0, 32'h0,           1, 0,  1, 0,  0,  0, 1, 0});
        tbl.push_back('{2,   1, 1, 100, 0,  0, 32'h0,           1, 1,  1, 1, 300, 1, 1, 0});
        tbl.push_back('{2,   2, 1, 101, 1,  0, init_word(100),  1, 1,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{2, 102, 0,  0,  0,  0, 32'h0,           0, 0,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{2, 257, 0,  0,  0,  0, 32'h0,           0, 0,  1, 0,  0,  0, 1, 0});
        tbl.push_back('{3,   1, 0,  0,  0,  0, 32'h0,           0, 0,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{3,   2, 0,  0,  0,  0, 32'h0,           0, 0,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{4,   1, 0,  0,  0,  0, 32'h0,           0, 0,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{5,   1, 1,  0,  0,  0, 32'h0,           0, 1,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{5,   2, 1,  1,  1,  0, init_word(0),    0, 1,  0, 0,  0,  0, 0, 0});
        tbl.push_back('{5, 102, 0,  0,  0,  0, 32'h0,           1, 0,  0, 0,  0,  0, 0, 0});

        for (int h = 0; h < 3; h++) do_cycle(-1, 0, h, 1'b1);
        model_on = 1;

        run_line(0, 27, -1);
        run_line(1, 28, -1);
        run_line(2, 29, -1);
        run_line(3, 628, -1);
        run_line(4, 0, -1);
        run_line(5, 28, -1);
        run_line(6, 29, 50);
        run_line(7, 30, -1);
        arm(0, 1'b0, 5, 32'h0);
        run_line(8, 28, -1);
        arm(10, 1'b1, 7, 32'hCAFE_0001);
        run_line(9, 5, -1);
        arm(20, 1'b0, 7, 32'h0);
        run_line(10, 5, -1);

        rand_mode = 1;
        for (int i = 0; i < 8; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 27) : 28 + i;
            run_line(11 + i, v, -1);
        end
        rand_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
